control_sequencer: RTL and testbench

- Hardwired multi-cycle control unit directly upstream of the datapath.
- Consumes the IR contents and the memory-ready flag.
- Drives every datapath strobe (register in/out selects, MAR/MDR/PC/IR/Y/Z/HI/LO enables, Read/Write, ALU opcode) one T-step per clock.
- Sequences fetch, decode and execute for the load/store, ALU, mul/div, move-from-HI/LO, nop and halt classes.

---
 rtl/control_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch / decode / execute T-step sequencer.
// Ports: clk, clr (async active-low), IR, mem_rdy in; datapath strobes, opcode, run out.
module control_sequencer #(
  parameter logic [4:0] OP_ADD = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        mem_rdy,
  output logic        PCout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        MDRout,
  output logic        BAout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        ZHighin,
  output logic        ZLowin,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  opcode,
  output logic        run
);

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  state_t r_state;
  // Set after a T1 cycle without mem_rdy, so PCin fires only once per fetch.
  logic   r_t1_hold;

  logic [4:0] w_op;
  logic w_ld, w_ldi, w_st, w_alu, w_alui;
  logic w_md, w_mfhi, w_mflo, w_halt, w_addr;

  assign w_op   = IR[31:27];
  assign w_ld   = (w_op == 5'd0);
  assign w_ldi  = (w_op == 5'd1);
  assign w_st   = (w_op == 5'd2);
  assign w_alu  = (w_op >= 5'd3) && (w_op <= 5'd12);
  assign w_alui = (w_op >= 5'd13) && (w_op <= 5'd15);
  assign w_md   = (w_op == 5'd16) || (w_op == 5'd17);
  assign w_mfhi = (w_op == 5'd23);
  assign w_mflo = (w_op == 5'd24);
  assign w_halt = (w_op == 5'd26);
  assign w_addr = w_ld | w_ldi | w_st;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= T0;
      r_t1_hold <= 1'b0;
    end else begin
      r_t1_hold <= (r_state == T1) && !mem_rdy;
      case (r_state)
        T0: r_state <= T1;
        T1: if (mem_rdy) r_state <= T2;
        T2: begin
          if (w_addr | w_alu | w_alui | w_md | w_mfhi | w_mflo)
            r_state <= T3;
          else if (w_halt)
            r_state <= HALT;
          else
            r_state <= T0;
        end
        T3: r_state <= (w_mfhi | w_mflo) ? T0 : T4;
        T4: r_state <= T5;
        T5: r_state <= (w_ld | w_st | w_md) ? T6 : T0;
        T6: begin
          if (w_ld) begin
            if (mem_rdy) r_state <= T7;
          end else if (w_st) begin
            r_state <= T7;
          end else begin
            r_state <= T0;
          end
        end
        T7: begin
          if (w_ld || mem_rdy) r_state <= T0;
        end
        HALT: r_state <= HALT;
        default: r_state <= T0;
      endcase
    end
  end

  always_comb begin
    PCout = 1'b0; ZHighout = 1'b0; ZLowout = 1'b0;
    MDRout = 1'b0; BAout = 1'b0; Cout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0;
    IRin = 1'b0; Yin = 1'b0; ZHighin = 1'b0;
    ZLowin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; IncPC = 1'b0;
    Read = 1'b0; Write = 1'b0;
    opcode = 5'd0;
    run = 1'b0;
    // Gated by clr directly so strobes drop without waiting for a clock.
    if (clr) begin
      run = (r_state != HALT);
      case (r_state)
        T0: begin
          PCout = 1'b1; MARin = 1'b1;
          IncPC = 1'b1; ZLowin = 1'b1;
          opcode = OP_ADD;
        end
        T1: begin
          ZLowout = 1'b1;
          PCin = !r_t1_hold;
          Read = 1'b1; MDRin = 1'b1;
        end
        T2: begin
          MDRout = 1'b1; IRin = 1'b1;
        end
        T3: begin
          if (w_addr) begin
            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
          end else if (w_alu | w_alui) begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end else if (w_md) begin
            Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end else if (w_mfhi) begin
            ZHighout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end else if (w_mflo) begin
            ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
        end
        T4: begin
          if (w_addr) begin
            Cout = 1'b1; opcode = OP_ADD; ZLowin = 1'b1;
          end else if (w_alu) begin
            Grc = 1'b1; Rout = 1'b1;
            opcode = w_op; ZLowin = 1'b1;
          end else if (w_alui) begin
            Cout = 1'b1; opcode = w_op; ZLowin = 1'b1;
          end else if (w_md) begin
            Grb = 1'b1; Rout = 1'b1; opcode = w_op;
            ZHighin = 1'b1; ZLowin = 1'b1;
          end
        end
        T5: begin
          ZLowout = 1'b1;
          if (w_ld | w_st) MARin = 1'b1;
          else if (w_md) LOin = 1'b1;
          else begin
            Gra = 1'b1; Rin = 1'b1;
          end
        end
        T6: begin
          if (w_ld) begin
            Read = 1'b1; MDRin = 1'b1;
          end else if (w_st) begin
            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
          end else begin
            ZHighout = 1'b1; HIin = 1'b1;
          end
        end
        T7: begin
          if (w_ld) begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end else begin
            Write = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: random instruction stream
// compared against a step-list reference model of the control sequences.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr, mem_rdy;
  logic [31:0] IR;
  logic PCout, ZHighout, ZLowout, MDRout, BAout, Cout;
  logic MARin, PCin, MDRin, IRin, Yin, ZHighin, ZLowin, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write;
  logic [4:0] opcode;
  logic run;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .mem_rdy(mem_rdy),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout),
    .MDRout(MDRout), .BAout(BAout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .ZHighin(ZHighin), .ZLowin(ZLowin),
    .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .opcode(opcode), .run(run)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic PCout, ZHighout, ZLowout, MDRout, BAout, Cout;
    logic MARin, PCin, MDRin, IRin, Yin, ZHighin, ZLowin, HIin, LOin;
    logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write;
    logic [4:0] opcode;
    logic run;
  } sv_t;

  sv_t obs;
  assign obs = {PCout, ZHighout, ZLowout, MDRout, BAout, Cout,
                MARin, PCin, MDRin, IRin, Yin, ZHighin, ZLowin, HIin, LOin,
                Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write,
                opcode, run};

  localparam logic [4:0] ADD = 5'b00011;

  sv_t  eq[$];
  logic rq[$];
  int   errs = 0;
  int   checks = 0;
  bit   at_t0 = 0;

  function automatic sv_t base();
    sv_t s = '0;
    s.run = 1'b1;
    return s;
  endfunction

  function automatic sv_t t0v();
    sv_t s = base();
    s.PCout = 1; s.MARin = 1; s.IncPC = 1; s.ZLowin = 1;
    s.opcode = ADD;
    return s;
  endfunction

  // Append one step; a memory step is repeated for each wait cycle.
  task automatic add_step(input sv_t s, input int waits, input bit mem);
    if (!mem) begin
      eq.push_back(s);
      rq.push_back(1'($urandom_range(0, 1)));
    end else begin
      for (int i = 0; i < waits; i++) begin
        eq.push_back(s);
        rq.push_back(1'b0);
      end
      eq.push_back(s);
      rq.push_back(1'b1);
    end
  endtask

  task automatic build(input logic [4:0] op, input int wf, input int wm);
    sv_t s;
    eq.delete();
    rq.delete();
    add_step(t0v(), 0, 0);
    s = base(); s.ZLowout = 1; s.PCin = 1; s.Read = 1; s.MDRin = 1;
    if (wf == 0) add_step(s, 0, 1);
    else begin
      eq.push_back(s); rq.push_back(1'b0);
      s.PCin = 0;
      add_step(s, wf - 1, 1);
    end
    s = base(); s.MDRout = 1; s.IRin = 1;
    add_step(s, 0, 0);
    if (op <= 2) begin
      s = base(); s.Grb = 1; s.BAout = 1; s.Yin = 1;
      add_step(s, 0, 0);
      s = base(); s.Cout = 1; s.opcode = ADD; s.ZLowin = 1;
      add_step(s, 0, 0);
      if (op == 1) begin
        s = base(); s.ZLowout = 1; s.Gra = 1; s.Rin = 1;
        add_step(s, 0, 0);
      end else begin
        s = base(); s.ZLowout = 1; s.MARin = 1;
        add_step(s, 0, 0);
        if (op == 0) begin
          s = base(); s.Read = 1; s.MDRin = 1;
          add_step(s, wm, 1);
          s = base(); s.MDRout = 1; s.Gra = 1; s.Rin = 1;
          add_step(s, 0, 0);
        end else begin
          s = base(); s.Gra = 1; s.Rout = 1; s.MDRin = 1;
          add_step(s, 0, 0);
          s = base(); s.Write = 1;
          add_step(s, wm, 1);
        end
      end
    end else if (op <= 15) begin
      s = base(); s.Grb = 1; s.Rout = 1; s.Yin = 1;
      add_step(s, 0, 0);
      s = base(); s.opcode = op; s.ZLowin = 1;
      if (op <= 12) begin s.Grc = 1; s.Rout = 1; end
      else s.Cout = 1;
      add_step(s, 0, 0);
      s = base(); s.ZLowout = 1; s.Gra = 1; s.Rin = 1;
      add_step(s, 0, 0);
    end else if (op == 16 || op == 17) begin
      s = base(); s.Gra = 1; s.Rout = 1; s.Yin = 1;
      add_step(s, 0, 0);
      s = base(); s.Grb = 1; s.Rout = 1; s.opcode = op;
      s.ZHighin = 1; s.ZLowin = 1;
      add_step(s, 0, 0);
      s = base(); s.ZLowout = 1; s.LOin = 1;
      add_step(s, 0, 0);
      s = base(); s.ZHighout = 1; s.HIin = 1;
      add_step(s, 0, 0);
    end else if (op == 23 || op == 24) begin
      s = base(); s.Gra = 1; s.Rin = 1;
      if (op == 23) s.ZHighout = 1; else s.ZLowout = 1;
      add_step(s, 0, 0);
    end
  endtask

  // Clocks from T0 to the next T0 as stated for each class.
  function automatic int spec_lat(input logic [4:0] op, input int wf, input int wm);
    int b;
    if (op == 0) b = 8 + wm;
    else if (op == 1) b = 6;
    else if (op == 2) b = 8 + wm;
    else if (op <= 15) b = 6;
    else if (op == 16 || op == 17) b = 7;
    else if (op == 23 || op == 24) b = 4;
    else b = 3;
    return b + wf;
  endfunction

  task automatic run_instr(input logic [4:0] op, input int wf, input int wm,
                           output int lat);
    build(op, wf, wm);
    IR = {op, 27'($urandom)};
    lat = -1;
    for (int i = 0; i < eq.size(); i++) begin
      if (!(i == 0 && at_t0)) @(negedge clk);
      mem_rdy = rq[i];
      #1;
      checks++;
      if (obs !== eq[i])
        $display("FAIL step op=%b i=%0d got=%h exp=%h", op, i, obs, eq[i]);
      if (obs !== eq[i]) errs++;
      checks++;
      if (Read && Write) begin
        errs++;
        $display("FAIL rw_excl op=%b i=%0d got=11 exp=not both", op, i);
      end
    end
    at_t0 = 0;
    if (op != 5'd26) begin
      @(negedge clk);
      mem_rdy = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (obs !== t0v()) begin
        errs++;
        $display("FAIL back_to_t0 op=%b got=%h exp=%h", op, obs, t0v());
      end else begin
        lat = eq.size();
      end
      at_t0 = 1;
    end
  endtask

  task automatic test_reset();
    int lat;
    clr = 1'b0; mem_rdy = 1'b0; IR = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      errs++;
      $display("FAIL reset_idle got=%h exp=0", obs);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (obs !== t0v()) begin
      errs++;
      $display("FAIL reset_t0 got=%h exp=%h", obs, t0v());
    end
    at_t0 = 1;
    build(ADD, 0, 0);
    IR = 32'h18908000;
    for (int i = 0; i <= 4; i++) begin
      if (i != 0) @(negedge clk);
      mem_rdy = rq[i];
      #1;
      checks++;
      if (obs !== eq[i]) begin
        errs++;
        $display("FAIL pre_abort i=%0d got=%h exp=%h", i, obs, eq[i]);
      end
    end
    #1 clr = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errs++;
      $display("FAIL abort_same_cycle got=%h exp=0", obs);
    end
    @(negedge clk);
    clr = 1'b1;
    #1;
    checks++;
    if (obs !== t0v()) begin
      errs++;
      $display("FAIL abort_restart got=%h exp=%h", obs, t0v());
    end
    at_t0 = 1;
    run_instr(ADD, 0, 0, lat);
  endtask

  task automatic test_alu();
    int lat;
    run_instr(ADD, 0, 0, lat);
    checks++;
    if (lat !== 6) begin
      errs++;
      $display("FAIL add_latency got=%0d exp=6", lat);
    end
    run_instr(5'd14, 0, 0, lat);
    checks++;
    if (lat !== 6) begin
      errs++;
      $display("FAIL alui_latency got=%0d exp=6", lat);
    end
  endtask

  task automatic test_fetch_wait();
    int lat;
    run_instr(5'd7, 3, 0, lat);
    checks++;
    if (lat !== 9) begin
      errs++;
      $display("FAIL fetch_wait_latency got=%0d exp=9", lat);
    end
  endtask

  task automatic test_mem();
    int lat;
    run_instr(5'd2, 0, 2, lat);
    checks++;
    if (lat !== 10) begin
      errs++;
      $display("FAIL st_wait_latency got=%0d exp=10", lat);
    end
    run_instr(5'd0, 0, 0, lat);
    checks++;
    if (lat !== 8) begin
      errs++;
      $display("FAIL ld_latency got=%0d exp=8", lat);
    end
    run_instr(5'd0, 1, 2, lat);
    checks++;
    if (lat !== 11) begin
      errs++;
      $display("FAIL ld_wait_latency got=%0d exp=11", lat);
    end
  endtask

  task automatic test_muldiv();
    int lat;
    run_instr(5'd16, 0, 0, lat);
    checks++;
    if (lat !== 7) begin
      errs++;
      $display("FAIL mul_latency got=%0d exp=7", lat);
    end
    run_instr(5'd24, 0, 0, lat);
    run_instr(5'd23, 0, 0, lat);
  endtask

  task automatic test_nop();
    int lat;
    run_instr(5'd31, 0, 0, lat);
    checks++;
    if (lat !== 3) begin
      errs++;
      $display("FAIL unlisted_latency got=%0d exp=3", lat);
    end
    run_instr(5'd25, 0, 0, lat);
  endtask

  task automatic test_random();
    int lat;
    logic [4:0] op;
    int wf, wm;
    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd26) op = 5'd25;
      wf = $urandom_range(0, 3);
      wm = $urandom_range(0, 3);
      run_instr(op, wf, wm, lat);
      checks++;
      if (lat !== spec_lat(op, wf, wm)) begin
        errs++;
        $display("FAIL rand_latency op=%b got=%0d exp=%0d",
                 op, lat, spec_lat(op, wf, wm));
      end
    end
  endtask

  task automatic test_halt();
    int lat;
    run_instr(5'd26, 1, 0, lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_rdy = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (obs !== '0) begin
        errs++;
        $display("FAIL halt_idle i=%0d got=%h exp=0", i, obs);
      end
    end
    clr = 1'b0;
    #1;
    @(negedge clk);
    clr = 1'b1;
    #1;
    checks++;
    if (obs !== t0v()) begin
      errs++;
      $display("FAIL halt_exit got=%h exp=%h", obs, t0v());
    end
    at_t0 = 1;
    run_instr(ADD, 0, 0, lat);
    checks++;
    if (lat !== 6) begin
      errs++;
      $display("FAIL post_halt_latency got=%0d exp=6", lat);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_fetch_wait();
    test_mem();
    test_muldiv();
    test_nop();
    test_random();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
